// File: rtl/seq_divider.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per enabled cycle.
// Optional macro DIV_SIGNED_EN selects two's-complement operation (magnitude core plus sign fix-up).
module seq_divider (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        clken,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] numer,
   input  logic [7:0]  denom,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] quotient,
   output logic [7:0]  remain,
   output logic        div_by_zero
);

   localparam int unsigned NUM_W = 16;
   localparam int unsigned DEN_W = 8;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned REM_W = DEN_W + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [REM_W-1:0]   r_rem;
   logic [NUM_W-1:0]   r_num;
   logic [DEN_W-1:0]   r_den;

   logic [NUM_W-1:0]   w_numer_mag;
   logic [DEN_W-1:0]   w_denom_mag;
   logic [REM_W:0]     w_trial;
   logic               w_qbit;
   logic [REM_W-1:0]   w_rem_nx;
   logic [NUM_W-1:0]   w_q_nx;
   logic [NUM_W-1:0]   w_q_fix;
   logic [DEN_W-1:0]   w_r_fix;
   logic               w_last;

`ifdef DIV_SIGNED_EN
   logic               r_qneg;
   logic               r_rneg;

   assign w_numer_mag = numer[NUM_W-1] ? NUM_W'(~numer + 16'd1) : numer;
   assign w_denom_mag = denom[DEN_W-1] ? DEN_W'(~denom + 8'd1) : denom;
   assign w_q_fix     = r_qneg ? NUM_W'(~w_q_nx + 16'd1) : w_q_nx;
   assign w_r_fix     = r_rneg ? DEN_W'(~w_rem_nx[DEN_W-1:0] + 8'd1) : w_rem_nx[DEN_W-1:0];
`else
   assign w_numer_mag = numer;
   assign w_denom_mag = denom;
   assign w_q_fix     = w_q_nx;
   assign w_r_fix     = w_rem_nx[DEN_W-1:0];
`endif

   // One restoring step: shift in the next dividend bit, subtract if it fits
   assign w_trial  = {r_rem, r_num[NUM_W-1]};
   assign w_qbit   = (w_trial >= (REM_W+1)'(r_den));
   assign w_rem_nx = REM_W'(w_qbit ? (w_trial - (REM_W+1)'(r_den)) : w_trial);
   assign w_q_nx   = {r_num[NUM_W-2:0], w_qbit};
   assign w_last   = (r_cnt == CNT_W'(NUM_W - 1));

   always_ff @(posedge clock) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = clken;
            if (clken && in_valid)
               w_next = (denom == '0) ? DONE : CALC;
         end
         CALC: begin
            if (clken && w_last)
               w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (clken && out_ready)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Datapath; results are only written on DONE entry so they hold across IDLE
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_num       <= '0;
         r_den       <= '0;
         quotient    <= '0;
         remain      <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
`endif
      end else if (clken) begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_cnt <= '0;
                  r_rem <= '0;
                  r_num <= w_numer_mag;
                  r_den <= w_denom_mag;
`ifdef DIV_SIGNED_EN
                  r_qneg <= numer[NUM_W-1] ^ denom[DEN_W-1];
                  r_rneg <= numer[NUM_W-1];
`endif
                  if (denom == '0) begin
                     quotient    <= '1;
                     remain      <= numer[DEN_W-1:0];
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_rem <= w_rem_nx;
               r_num <= w_q_nx;
               if (w_last) begin
                  quotient    <= w_q_fix;
                  remain      <= w_r_fix;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operand pairs with hand-computed results,
// a monitor that checks every consumed result, plus latency, stall, clock-enable and reset checks.
module tb_seq_divider;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        clken;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] numer;
   logic [7:0]  denom;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remain;
   logic        div_by_zero;

   typedef struct packed {
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Latency counted in edges from the accept edge inclusive: 16 CALC edges follow the accept
   localparam int LAT_CALC = 17;
   localparam int LAT_DIV0 = 1;

   seq_divider dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .clken       (clken),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .numer       (numer),
      .denom       (denom),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remain      (remain),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: a result is consumed at the next edge whenever valid, ready and enable line up
   always @(negedge clock) begin
      if (rst_n && clken && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'(quotient), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_quotient", 32'(quotient), 32'(e.q));
            check("sb_remain", 32'(remain), 32'(e.r));
            check("sb_div_by_zero", 32'(div_by_zero), 32'(e.z));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_op(input string name, input logic [15:0] n, input logic [7:0] d,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez,
                        input int exp_lat, input int stall, input int gap_at, input int gap_len);
      exp_t e;
      int   lat;
      out_ready = (stall == 0);
      numer     = n;
      denom     = d;
      in_valid  = 1'b1;
      #1;
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      e.q = eq; e.r = er; e.z = ez;
      sb_q.push_back(e);
      @(posedge clock); #1;
      in_valid = 1'b0;
      numer    = 16'($urandom);
      denom    = 8'($urandom);
      lat      = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clock); #1;
         lat++;
         if (gap_len > 0 && lat == gap_at)           clken = 1'b0;
         if (gap_len > 0 && lat == gap_at + gap_len) clken = 1'b1;
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         @(negedge clock);
         check({name, "_stall_q"}, 32'(quotient), 32'(eq));
         check({name, "_stall_r"}, 32'(remain), 32'(er));
         check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
         check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
         @(posedge clock); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check({name, "_post_valid"}, 32'(out_valid), 32'd0);
      check({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
      check({name, "_hold_q"}, 32'(quotient), 32'(eq));
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      clken     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      numer     = '0;
      denom     = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remain", 32'(remain), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_in_ready_clken_low", 32'(in_ready), 32'd0);
      clken = 1'b1;
      @(posedge clock); #1;
      rst_n = 1'b1;
      #1;
      check("rst_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock); #1;

`ifdef DIV_SIGNED_EN
      do_op("s_m100_7",   16'hFF9C, 8'd7,   16'hFFF2, 8'hFE, 1'b0, LAT_CALC, 0, 0, 0);
      do_op("s_100_m7",   16'd100,  8'hF9,  16'hFFF2, 8'h02, 1'b0, LAT_CALC, 0, 0, 0);
      do_op("s_m100_m7",  16'hFF9C, 8'hF9,  16'h000E, 8'hFE, 1'b0, LAT_CALC, 0, 0, 0);
      do_op("s_min_m1",   16'h8000, 8'hFF,  16'h8000, 8'h00, 1'b0, LAT_CALC, 0, 0, 0);
      do_op("s_div0",     16'h1234, 8'd0,   16'hFFFF, 8'h34, 1'b1, LAT_DIV0, 0, 0, 0);
      do_op("s_1000_7",   16'd1000, 8'd7,   16'd142,  8'd6,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("s_stall",    16'hFFFF, 8'hFF,  16'd1,    8'd0,  1'b0, LAT_CALC, 5, 0, 0);
`else
      do_op("u_1000_7",   16'd1000,  8'd7,   16'd142,  8'd6,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("u_div0",     16'h1234,  8'd0,   16'hFFFF, 8'h34, 1'b1, LAT_DIV0, 0, 0, 0);
      do_op("u_stall",    16'hFFFF,  8'd255, 16'd257,  8'd0,  1'b0, LAT_CALC, 5, 0, 0);
      do_op("u_div1",     16'hFFFF,  8'd1,   16'hFFFF, 8'd0,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("u_small",    16'd7,     8'd10,  16'd0,    8'd7,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("u_zero_num", 16'd0,     8'd5,   16'd0,    8'd0,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("u_40000",    16'd40000, 8'd200, 16'd200,  8'd0,  1'b0, LAT_CALC, 0, 0, 0);
      do_op("u_12345",    16'd12345, 8'd128, 16'd96,   8'd57, 1'b0, LAT_CALC, 0, 0, 0);
`endif
      // Clock enable low for 3 cycles after 5 CALC edges stretches latency by 3
      do_op("clken_gap",  16'd500,   8'd3,   16'd166,  8'd2,  1'b0, LAT_CALC + 3, 0, 6, 3);

      // Reset in the middle of CALC discards the operation
      numer    = 16'd1000;
      denom    = 8'd7;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      rst_n = 1'b0;
      @(posedge clock); #1;
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remain", 32'(remain), 32'd0);
      check("midrst_dbz", 32'(div_by_zero), 32'd0);
      seen = 0;
      repeat (25) begin
         @(posedge clock); #1;
         if (out_valid) seen++;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Ports SHALL be, in order (name, direction, width, meaning):
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 clken  input  1  clock enable; low freezes all state and blocks handshakes.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  divider can accept operands; equals (state==IDLE) && clken.
REQ-007 numer  input  16  dividend.
REQ-008 denom  input  8  divisor.
REQ-009 out_valid  output  1  result valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  16  quotient.
REQ-012 remain  output  8  remainder.
REQ-013 div_by_zero  output  1  flags a result produced with denom==0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 Input transfer SHALL occur on an edge where in_valid && in_ready; numer and denom are captured, and state goes IDLE->CALC (denom!=0) or IDLE->DONE (denom==0).
REQ-016 CALC SHALL perform restoring division, one quotient bit per enabled edge, MSB first, with a 5-bit step counter and 9-bit partial remainder.
REQ-017 After exactly 16 enabled CALC edges the state SHALL go to DONE; out_valid asserts 16 enabled edges after the accept edge.
REQ-018 Divide by zero SHALL produce quotient=16'hFFFF, remain=numer[7:0], div_by_zero=1, with out_valid one enabled edge after accept.
REQ-019 div_by_zero SHALL be 0 for every nonzero-divisor result.
REQ-020 Output transfer SHALL occur on an edge where out_valid && out_ready && clken; state goes DONE->IDLE; quotient, remain and div_by_zero hold their values until the next accepted operation completes.
REQ-021 In DONE with out_ready low, quotient, remain, div_by_zero and out_valid SHALL be held stable indefinitely.
REQ-022 in_ready SHALL be 0 in CALC and DONE; no new operation is accepted in the same edge a result is consumed.
REQ-023 While clken is low, state, counter, partial remainder and outputs SHALL hold; the latency extends by the number of disabled cycles.
REQ-024 Operand changes after acceptance SHALL NOT affect the result in progress.
REQ-025 Unsigned build: quotient = floor(numer/denom), remain = numer mod denom; denom=1 gives quotient=numer, remain=0.

Reset
REQ-026 When rst_n is low at a rising edge, regardless of clken, state SHALL go to IDLE and quotient, remain, div_by_zero, out_valid and the counter SHALL go to 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid follows.
REQ-028 in_ready SHALL be 1 on the first cycle after reset release if clken is high.

Configuration
REQ-029 Macro DIV_SIGNED_EN SHALL select signed operation; without it, all operands and results are unsigned.
REQ-030 With DIV_SIGNED_EN, numer, denom, quotient and remain SHALL be two's complement; quotient truncates toward zero; remain takes the sign of numer; the core divides magnitudes and fixes signs in the DONE-entry edge with no added latency.
REQ-031 With DIV_SIGNED_EN, -32768 / -1 SHALL return quotient=16'h8000 (wrap), remain=0; divide by zero SHALL behave as in REQ-018.

Verification
REQ-032 numer=1000, denom=7, out_ready=1 -> quotient=142, remain=6, div_by_zero=0, out_valid 16 edges after accept.
REQ-033 numer=16'h1234, denom=0 -> quotient=16'hFFFF, remain=8'h34, div_by_zero=1, out_valid 1 edge after accept.
REQ-034 65535/255 with out_ready held low for 5 cycles after out_valid -> quotient=257, remain=0, stable for all 5 cycles, in_ready=0; output transfers on the first edge with out_ready=1, then in_ready=1.
REQ-035 rst_n low for one edge at the 8th CALC cycle -> next cycle state IDLE, all outputs 0, in_ready=1; no out_valid follows.
REQ-036 clken low for 3 cycles mid-CALC on 500/3 -> quotient=166, remain=2, out_valid at 19 cycles after accept.
REQ-037 DIV_SIGNED_EN defined, numer=-100, denom=7 -> quotient=16'hFFF2 (-14), remain=8'hFE (-2).
